hasti_debug_master: RTL and testbench
=====================================

Name: hasti_debug_master

Overview:
- Far end of the debug request/response channel. Consumes 2-bit-command/32-bit-data debug requests, executes them as single-word HASTI (AHB-Lite) master transfers, and returns an ack-bit/32-bit-data response.
- Sits in the system clock domain, between the deq side of the debug request FIFO, the enq side of the response FIFO, and the HASTI interconnect.
- Holds an auto-incrementing address register so that streams of reads or writes need no per-word address command.

Parameters:
- RESET_ADDR, 32'h00000000, value loaded into the address register on reset.
- ADDR_INC, 4, byte increment applied to the address register after each successful (OKAY) bus transfer.
- HPROT_VAL, 4'b0011, constant driven on io_mem_hprot (non-cacheable, non-bufferable, privileged data).

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- io_req_ready  out  1  block accepts a request this cycle
- io_req_valid  in  1  request present
- io_req_bits_cmd  in  2  0=SET_ADDR, 1=WRITE, 2=READ, 3=GET_ADDR
- io_req_bits_data  in  32  address (SET_ADDR) or write data (WRITE); ignored otherwise
- io_resp_ready  in  1  response consumer ready
- io_resp_valid  out  1  response present
- io_resp_bits_ack  out  1  1=success, 0=bus error
- io_resp_bits_data  out  32  response payload
- io_mem_haddr  out  32  HASTI address
- io_mem_hwrite  out  1  write transfer
- io_mem_hsize  out  3  constant 3'b010 (word)
- io_mem_hburst  out  3  constant 3'b000 (SINGLE)
- io_mem_hmastlock  out  1  constant 0
- io_mem_hprot  out  4  constant HPROT_VAL
- io_mem_htrans  out  2  2'b00 IDLE or 2'b10 NONSEQ only
- io_mem_hwdata  out  32  write data, valid in the data phase
- io_mem_hrdata  in  32  read data
- io_mem_hready  in  1  transfer done / address accepted
- io_mem_hresp  in  1  0=OKAY, 1=ERROR

Behaviour:
- Reset values: FSM=IDLE, addr=RESET_ADDR, io_req_ready=1, io_resp_valid=0, io_resp_bits_ack=0, io_resp_bits_data=0, htrans=IDLE, hwrite=0, haddr=RESET_ADDR, hwdata=0.
- Request handshake:
  - A request fires on io_req_valid && io_req_ready.
  - io_req_ready=1 only in IDLE, so at most one request is outstanding.
  - cmd, data and addr are latched at fire.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - On fire with cmd 0 or 3, go to RESP next cycle; no bus activity.
  - SET_ADDR: addr<=data with bits [1:0] forced to 0; response data = new addr, ack=1.
  - GET_ADDR: response data = current addr, ack=1.
  - On fire with cmd 1 or 2, go to ADDR.
- ADDR:
  - Drive htrans=NONSEQ, haddr=addr, hwrite=(cmd==WRITE).
  - If hready=1, go to DATA; otherwise hold all address-phase signals unchanged.
- DATA:
  - htrans=IDLE; hwdata=latched write data, held stable until hready=1.
  - On hready=1: capture ack=!hresp. Response data = hrdata for READ, or the transfer address for WRITE.
  - If hresp=0, addr<=addr+ADDR_INC. This wraps modulo 2^32, so 0xFFFFFFFC+4 -> 0x00000000.
  - If hresp=1, addr is unchanged.
  - Go to RESP.
  - The first ERROR cycle (hready=0, hresp=1) is ignored; capture happens only on the hready=1 cycle.
- RESP:
  - io_resp_valid=1; bits are registered and stable while valid.
  - On io_resp_ready=1, go to IDLE with io_resp_valid=0 next cycle.
  - Stalls indefinitely while io_resp_ready=0.
- Latency, fire to io_resp_valid:
  - cmd 0/3: 1 cycle.
  - cmd 1/2 with zero-wait slave: 3 cycles; each hready-low cycle adds 1.
  - Minimum back-to-back throughput is one request per 2 cycles (non-bus) or per 4 cycles (bus).
- A request arriving while not in IDLE stays pending; it is never dropped.
- Reset asserted mid-operation: on the next edge, all state returns to reset values, including htrans=IDLE, and any pending response is discarded.
- The FSM never issues NONSEQ while in DATA or RESP, so there are no pipelined transfers.

Test Plan:
- SET_ADDR 0x80001003, then GET_ADDR -> both responses ack=1, data=0x80001000; htrans stays IDLE throughout.
- SET_ADDR 0x100; WRITE 0xCAFEF00D; WRITE 0x12345678, zero-wait slave -> NONSEQ at haddr 0x100 then 0x104 with hwrite=1; hwdata matches in each data phase; responses ack=1, data 0x100/0x104; GET_ADDR returns 0x108.
- READ at 0x200 with slave inserting 3 wait states, hrdata=0xDEADBEEF -> fire-to-resp latency is 6 cycles; resp ack=1, data=0xDEADBEEF; addr becomes 0x204.
- READ with two-cycle ERROR response -> ack=0; addr is not incremented (GET_ADDR returns the same address).
- SET_ADDR 0xFFFFFFFC; READ with OKAY -> addr wraps to 0x00000000. Hold io_resp_ready=0 for 10 cycles -> resp remains stable and io_req_ready=0 throughout.
- Assert reset during the DATA state of a WRITE -> next cycle htrans=IDLE, io_resp_valid=0, io_req_ready=1; GET_ADDR returns RESET_ADDR.

Source files
------------

// File: rtl/hasti_debug_master_if.sv
// Purpose: bundles the debug request/response channel and the HASTI master bus of hasti_debug_master.
// Latency: none; this is wiring only.
// Backpressure: carried by io_req_ready / io_resp_ready / io_mem_hready.
// Ports: master modport = the debug master's view; slave modport = the FIFOs plus the interconnect.
interface hasti_debug_master_if;
    // debug request channel (from the request FIFO deq side)
    logic        io_req_ready;
    logic        io_req_valid;
    logic [1:0]  io_req_bits_cmd;
    logic [31:0] io_req_bits_data;
    // debug response channel (to the response FIFO enq side)
    logic        io_resp_ready;
    logic        io_resp_valid;
    logic        io_resp_bits_ack;
    logic [31:0] io_resp_bits_data;
    // HASTI master port
    logic [31:0] io_mem_haddr;
    logic        io_mem_hwrite;
    logic [2:0]  io_mem_hsize;
    logic [2:0]  io_mem_hburst;
    logic        io_mem_hmastlock;
    logic [3:0]  io_mem_hprot;
    logic [1:0]  io_mem_htrans;
    logic [31:0] io_mem_hwdata;
    logic [31:0] io_mem_hrdata;
    logic        io_mem_hready;
    logic        io_mem_hresp;

    modport master (
        output io_req_ready,
        input  io_req_valid, io_req_bits_cmd, io_req_bits_data,
        input  io_resp_ready,
        output io_resp_valid, io_resp_bits_ack, io_resp_bits_data,
        output io_mem_haddr, io_mem_hwrite, io_mem_hsize, io_mem_hburst,
        output io_mem_hmastlock, io_mem_hprot, io_mem_htrans, io_mem_hwdata,
        input  io_mem_hrdata, io_mem_hready, io_mem_hresp
    );

    modport slave (
        input  io_req_ready,
        output io_req_valid, io_req_bits_cmd, io_req_bits_data,
        output io_resp_ready,
        input  io_resp_valid, io_resp_bits_ack, io_resp_bits_data,
        input  io_mem_haddr, io_mem_hwrite, io_mem_hsize, io_mem_hburst,
        input  io_mem_hmastlock, io_mem_hprot, io_mem_htrans, io_mem_hwdata,
        output io_mem_hrdata, io_mem_hready, io_mem_hresp
    );
endinterface

// File: rtl/hasti_debug_master.sv
// Purpose: executes debug requests (set/get address, single-word read/write) as HASTI master transfers.
// Latency: fire to response valid = 1 cycle for address commands, 3 cycles + slave wait states for bus commands.
// Backpressure: one request outstanding; io_req_ready only in IDLE, response held until io_resp_ready.
// Ports: clk, reset (sync, active high), bus = hasti_debug_master_if.master (req, resp and HASTI signals).
module hasti_debug_master #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_INC   = 32'd4,
    parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
    input  logic clk,
    input  logic reset,
    hasti_debug_master_if.master bus
);
    localparam logic [1:0] CMD_SET_ADDR = 2'd0;
    localparam logic [1:0] CMD_WRITE    = 2'd1;
    localparam logic [1:0] CMD_READ     = 2'd2;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [1:0]  cmd_q;
    logic [31:0] wdata_q;
    logic        ack_q;
    logic [31:0] resp_data_q;
    logic        fire;
    logic        is_bus_cmd;

    assign fire       = bus.io_req_valid && (state_q == S_IDLE);
    // WRITE (1) and READ (2) touch the bus; SET_ADDR (0) and GET_ADDR (3) do not
    assign is_bus_cmd = bus.io_req_bits_cmd[0] ^ bus.io_req_bits_cmd[1];

    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (fire) state_d = is_bus_cmd ? S_ADDR : S_RESP;
            S_ADDR: if (bus.io_mem_hready) state_d = S_DATA;
            S_DATA: if (bus.io_mem_hready) state_d = S_RESP;
            S_RESP: if (bus.io_resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // address register, latched request and registered response
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= RESET_ADDR;
            cmd_q       <= CMD_SET_ADDR;
            wdata_q     <= 32'h0;
            ack_q       <= 1'b0;
            resp_data_q <= 32'h0;
        end else begin
            if (fire) begin
                cmd_q   <= bus.io_req_bits_cmd;
                wdata_q <= bus.io_req_bits_data;
                if (!is_bus_cmd) begin
                    ack_q <= 1'b1;
                    if (bus.io_req_bits_cmd == CMD_SET_ADDR) begin
                        addr_q      <= {bus.io_req_bits_data[31:2], 2'b00};
                        resp_data_q <= {bus.io_req_bits_data[31:2], 2'b00};
                    end else begin
                        resp_data_q <= addr_q;
                    end
                end
            end
            // capture only on the hready=1 cycle; the first ERROR cycle (hready=0) is ignored
            if (state_q == S_DATA && bus.io_mem_hready) begin
                ack_q       <= !bus.io_mem_hresp;
                resp_data_q <= (cmd_q == CMD_READ) ? bus.io_mem_hrdata : addr_q;
                if (!bus.io_mem_hresp) addr_q <= addr_q + ADDR_INC;
            end
        end
    end

    // outputs; addr_q is frozen outside DATA completion, so the address phase holds while hready=0
    always_comb begin
        bus.io_req_ready      = (state_q == S_IDLE);
        bus.io_resp_valid     = (state_q == S_RESP);
        bus.io_resp_bits_ack  = ack_q;
        bus.io_resp_bits_data = resp_data_q;
        bus.io_mem_haddr      = addr_q;
        bus.io_mem_htrans     = (state_q == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        bus.io_mem_hwrite     = (state_q == S_ADDR) && (cmd_q == CMD_WRITE);
        bus.io_mem_hwdata     = wdata_q;
        bus.io_mem_hsize      = 3'b010;
        bus.io_mem_hburst     = 3'b000;
        bus.io_mem_hmastlock  = 1'b0;
        bus.io_mem_hprot      = HPROT_VAL;
    end
endmodule

// File: tb/tb_hasti_debug_master.sv
// Purpose: directed self-checking bench for hasti_debug_master with a cycle-stepped slave.
// Latency: measured from the request fire cycle to the first cycle io_resp_valid is seen.
// Backpressure: io_resp_ready stalls and pending requests are exercised explicitly.
module tb_hasti_debug_master;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    hasti_debug_master_if bus();

    hasti_debug_master #(
        .RESET_ADDR(32'h0000_0000),
        .ADDR_INC  (32'd4),
        .HPROT_VAL (4'b0011)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and plays a slave: address phase accepted at once, then
    // 'waits' hready-low data cycles (hresp=err during them), then the completing cycle.
    task automatic do_req(input logic [1:0] cmd, input logic [31:0] data, input int waits,
                          input logic err, input logic [31:0] rdata,
                          output logic ack, output logic [31:0] rdat, output int lat,
                          output logic [31:0] seen_haddr, output logic seen_hwrite,
                          output logic [31:0] seen_hwdata, output int nonseq_cnt);
        int  w;
        bit  in_data;
        bit  done;
        w = waits; in_data = 0; done = 0;
        ack = 1'b0; rdat = 32'h0; lat = -1; nonseq_cnt = 0;
        seen_haddr = 32'h0; seen_hwrite = 1'b0; seen_hwdata = 32'h0;
        for (int i = 0; i < 20 && bus.io_req_ready !== 1'b1; i++) tick();
        if (bus.io_req_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout got=%b want=1", bus.io_req_ready);
            return;
        end
        bus.io_req_valid     = 1'b1;
        bus.io_req_bits_cmd  = cmd;
        bus.io_req_bits_data = data;
        tick();
        bus.io_req_valid = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            if (bus.io_resp_valid === 1'b1) begin
                done = 1; lat = k;
                ack  = bus.io_resp_bits_ack;
                rdat = bus.io_resp_bits_data;
            end else begin
                bus.io_mem_hready = 1'b1; bus.io_mem_hresp = 1'b0; bus.io_mem_hrdata = 32'h0;
                if (bus.io_mem_htrans === 2'b10) begin
                    nonseq_cnt++;
                    seen_haddr  = bus.io_mem_haddr;
                    seen_hwrite = bus.io_mem_hwrite;
                    in_data     = 1;
                end else if (in_data) begin
                    seen_hwdata       = bus.io_mem_hwdata;
                    bus.io_mem_hresp  = err;
                    if (w > 0) begin
                        bus.io_mem_hready = 1'b0;
                        w--;
                    end else begin
                        bus.io_mem_hrdata = rdata;
                    end
                end
                tick();
            end
        end
        bus.io_mem_hready = 1'b1; bus.io_mem_hresp = 1'b0; bus.io_mem_hrdata = 32'h0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL resp_timeout got=no_resp want=resp_valid");
        end else if (bus.io_resp_ready) begin
            tick();
        end
    endtask

    task automatic test_reset();
        checks++; if (bus.io_req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got=%b want=1", bus.io_req_ready); end
        checks++; if (bus.io_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got=%b want=0", bus.io_resp_valid); end
        checks++; if (bus.io_resp_bits_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b want=0", bus.io_resp_bits_ack); end
        checks++; if (bus.io_resp_bits_data !== 32'h0) begin errors++; $display("FAIL rst_resp_data got=%h want=0", bus.io_resp_bits_data); end
        checks++; if (bus.io_mem_htrans !== 2'b00) begin errors++; $display("FAIL rst_htrans got=%b want=00", bus.io_mem_htrans); end
        checks++; if (bus.io_mem_hwrite !== 1'b0) begin errors++; $display("FAIL rst_hwrite got=%b want=0", bus.io_mem_hwrite); end
        checks++; if (bus.io_mem_haddr !== 32'h0) begin errors++; $display("FAIL rst_haddr got=%h want=0", bus.io_mem_haddr); end
        checks++; if (bus.io_mem_hwdata !== 32'h0) begin errors++; $display("FAIL rst_hwdata got=%h want=0", bus.io_mem_hwdata); end
        checks++; if (bus.io_mem_hsize !== 3'b010) begin errors++; $display("FAIL hsize got=%b want=010", bus.io_mem_hsize); end
        checks++; if (bus.io_mem_hburst !== 3'b000) begin errors++; $display("FAIL hburst got=%b want=000", bus.io_mem_hburst); end
        checks++; if (bus.io_mem_hmastlock !== 1'b0) begin errors++; $display("FAIL hmastlock got=%b want=0", bus.io_mem_hmastlock); end
        checks++; if (bus.io_mem_hprot !== 4'b0011) begin errors++; $display("FAIL hprot got=%b want=0011", bus.io_mem_hprot); end
    endtask

    task automatic test_set_get();
        logic ack; logic [31:0] d, ha, hw; logic wr; int lat, ns;
        do_req(2'd0, 32'h8000_1003, 0, 1'b0, 32'h0, ack, d, lat, ha, wr, hw, ns);
        checks++; if (ack !== 1'b1 || d !== 32'h8000_1000) begin errors++; $display("FAIL set_addr_resp got=%b/%h want=1/80001000", ack, d); end
        checks++; if (lat != 1) begin errors++; $display("FAIL set_addr_latency got=%0d want=1", lat); end
        checks++; if (ns != 0) begin errors++; $display("FAIL set_addr_nonseq got=%0d want=0", ns); end
        do_req(2'd3, 32'h0, 0, 1'b0, 32'h0, ack, d, lat, ha, wr, hw, ns);
        checks++; if (ack !== 1'b1 || d !== 32'h8000_1000) begin errors++; $display("FAIL get_addr_resp got=%b/%h want=1/80001000", ack, d); end
        checks++; if (ns != 0 || lat != 1) begin errors++; $display("FAIL get_addr_bus got=%0d/%0d want=0/1", ns, lat); end
    endtask

    task automatic test_write_stream();
        logic ack; logic [31:0] d, ha, hw; logic wr; int lat, ns;
        do_req(2'd0, 32'h0000_0100, 0, 1'b0, 32'h0, ack, d, lat, ha, wr, hw, ns);
        do_req(2'd1, 32'hCAFE_F00D, 0, 1'b0, 32'h0, ack, d, lat, ha, wr, hw, ns);
        checks++; if (ha !== 32'h100 || wr !== 1'b1 || ns != 1) begin errors++; $display("FAIL wr0_addr_phase got=%h/%b/%0d want=100/1/1", ha, wr, ns); end
        checks++; if (hw !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr0_hwdata got=%h want=cafef00d", hw); end
        checks++; if (ack !== 1'b1 || d !== 32'h100 || lat != 3) begin errors++; $display("FAIL wr0_resp got=%b/%h/%0d want=1/100/3", ack, d, lat); end
        do_req(2'd1, 32'h1234_5678, 0, 1'b0, 32'h0, ack, d, lat, ha, wr, hw, ns);
        checks++; if (ha !== 32'h104 || wr !== 1'b1 || ns != 1) begin errors++; $display("FAIL wr1_addr_phase got=%h/%b/%0d want=104/1/1", ha, wr, ns); end
        checks++; if (hw !== 32'h1234_5678) begin errors++; $display("FAIL wr1_hwdata got=%h want=12345678", hw); end
        checks++; if (ack !== 1'b1 || d !== 32'h104) begin errors++; $display("FAIL wr1_resp got=%b/%h want=1/104", ack, d); end
        do_req(2'd3, 32'h0, 0, 1'b0, 32'h0, ack, d, lat, ha, wr, hw, ns);
        checks++; if (d !== 32'h108) begin errors++; $display("FAIL wr_get_addr got=%h want=108", d); end
    endtask

    task automatic test_read_wait();
        logic ack; logic [31:0] d, ha, hw; logic wr; int lat, ns;
        do_req(2'd0, 32'h0000_0200, 0, 1'b0, 32'h0, ack, d, lat, ha, wr, hw, ns);
        do_req(2'd2, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, ack, d, lat, ha, wr, hw, ns);
        checks++; if (lat != 6) begin errors++; $display("FAIL rd_wait_latency got=%0d want=6", lat); end
        checks++; if (ack !== 1'b1 || d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_wait_resp got=%b/%h want=1/deadbeef", ack, d); end
        checks++; if (ha !== 32'h200 || wr !== 1'b0 || ns != 1) begin errors++; $display("FAIL rd_addr_phase got=%h/%b/%0d want=200/0/1", ha, wr, ns); end
        do_req(2'd3, 32'h0, 0, 1'b0, 32'h0, ack, d, lat, ha, wr, hw, ns);
        checks++; if (d !== 32'h204) begin errors++; $display("FAIL rd_get_addr got=%h want=204", d); end
    endtask

    task automatic test_read_error();
        logic ack; logic [31:0] d, ha, hw; logic wr; int lat, ns;
        do_req(2'd2, 32'h0, 1, 1'b1, 32'h1111_2222, ack, d, lat, ha, wr, hw, ns);
        checks++; if (ack !== 1'b0 || lat != 4) begin errors++; $display("FAIL rd_err_resp got=%b/%0d want=0/4", ack, lat); end
        do_req(2'd3, 32'h0, 0, 1'b0, 32'h0, ack, d, lat, ha, wr, hw, ns);
        checks++; if (d !== 32'h204) begin errors++; $display("FAIL rd_err_addr got=%h want=204", d); end
    endtask

    task automatic test_wrap_stall();
        logic ack; logic [31:0] d, ha, hw; logic wr; int lat, ns;
        do_req(2'd0, 32'hFFFF_FFFC, 0, 1'b0, 32'h0, ack, d, lat, ha, wr, hw, ns);
        bus.io_resp_ready = 1'b0;
        do_req(2'd2, 32'h0, 0, 1'b0, 32'h55AA_33CC, ack, d, lat, ha, wr, hw, ns);
        checks++; if (ack !== 1'b1 || d !== 32'h55AA_33CC || ha !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_rd_resp got=%b/%h/%h want=1/55aa33cc/fffffffc", ack, d, ha); end
        // a second request waits during the stall and must fire once the response drains
        bus.io_req_valid = 1'b1; bus.io_req_bits_cmd = 2'd3; bus.io_req_bits_data = 32'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.io_resp_valid !== 1'b1 || bus.io_req_ready !== 1'b0 ||
                bus.io_resp_bits_ack !== 1'b1 || bus.io_resp_bits_data !== 32'h55AA_33CC) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got=%b/%b/%b/%h want=1/0/1/55aa33cc", i,
                         bus.io_resp_valid, bus.io_req_ready, bus.io_resp_bits_ack, bus.io_resp_bits_data);
            end
        end
        bus.io_resp_ready = 1'b1;
        tick();
        checks++; if (bus.io_resp_valid !== 1'b0 || bus.io_req_ready !== 1'b1) begin errors++; $display("FAIL stall_release got=%b/%b want=0/1", bus.io_resp_valid, bus.io_req_ready); end
        tick();
        bus.io_req_valid = 1'b0;
        checks++; if (bus.io_resp_valid !== 1'b1 || bus.io_resp_bits_data !== 32'h0) begin errors++; $display("FAIL pending_get_wrap got=%b/%h want=1/00000000", bus.io_resp_valid, bus.io_resp_bits_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic ack; logic [31:0] d, ha, hw; logic wr; int lat, ns;
        do_req(2'd0, 32'h0000_0040, 0, 1'b0, 32'h0, ack, d, lat, ha, wr, hw, ns);
        bus.io_req_valid = 1'b1; bus.io_req_bits_cmd = 2'd1; bus.io_req_bits_data = 32'hA5A5_A5A5;
        tick();
        bus.io_req_valid = 1'b0;
        checks++; if (bus.io_mem_htrans !== 2'b10 || bus.io_mem_haddr !== 32'h40) begin errors++; $display("FAIL rm_addr_phase got=%b/%h want=10/40", bus.io_mem_htrans, bus.io_mem_haddr); end
        tick();
        bus.io_mem_hready = 1'b0;
        checks++; if (bus.io_mem_hwdata !== 32'hA5A5_A5A5 || bus.io_mem_htrans !== 2'b00) begin errors++; $display("FAIL rm_data_phase got=%h/%b want=a5a5a5a5/00", bus.io_mem_hwdata, bus.io_mem_htrans); end
        reset = 1'b1;
        tick();
        reset = 1'b0; bus.io_mem_hready = 1'b1;
        checks++; if (bus.io_mem_htrans !== 2'b00 || bus.io_resp_valid !== 1'b0 || bus.io_req_ready !== 1'b1) begin errors++; $display("FAIL rm_after_reset got=%b/%b/%b want=00/0/1", bus.io_mem_htrans, bus.io_resp_valid, bus.io_req_ready); end
        do_req(2'd3, 32'h0, 0, 1'b0, 32'h0, ack, d, lat, ha, wr, hw, ns);
        checks++; if (ack !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL rm_get_addr got=%b/%h want=1/00000000", ack, d); end
    endtask

    initial begin
        reset = 1'b1;
        bus.io_req_valid = 1'b0; bus.io_req_bits_cmd = 2'd0; bus.io_req_bits_data = 32'h0;
        bus.io_resp_ready = 1'b1;
        bus.io_mem_hready = 1'b1; bus.io_mem_hresp = 1'b0; bus.io_mem_hrdata = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_set_get();
        test_write_stream();
        test_read_wait();
        test_read_error();
        test_wrap_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
